serial_parity_checker: RTL and testbench

Bit-serial receiver and checker for the team's XOR parity scheme. It takes a serial stream made of DATA_W data bits, LSB first, followed by one parity bit. It rebuilds the data word with a running XOR accumulator and checks the received parity bit against it. Its outputs are the word, a one-cycle valid pulse and error flags to downstream logic. It is the receive-side counterpart of the XOR parity generator on the transmit side.

---
 rtl/serial_parity_checker_pkg.sv | 13 +
 rtl/serial_parity_checker_if.sv | 25 ++
 rtl/serial_parity_checker_acc.sv | 20 ++
 rtl/serial_parity_checker.sv | 88 ++++++++
 tb/tb_serial_parity_checker.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/serial_parity_checker_pkg.sv
// Shared definitions for the XOR parity receive/transmit pair.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/serial_parity_checker_if.sv
// Serial bit stream in, reassembled word and status out.
interface serial_parity_checker_if #(
  parameter int DATA_W = 8
);

  logic              ser_in;
  logic              bit_valid_in;
  logic              frame_start_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid_out;
  logic              parity_err_out;
  logic              frame_err_out;
  logic              busy_out;

  modport master (
    output ser_in, bit_valid_in, frame_start_in,
    input  data_out, data_valid_out, parity_err_out, frame_err_out, busy_out
  );

  modport slave (
    input  ser_in, bit_valid_in, frame_start_in,
    output data_out, data_valid_out, parity_err_out, frame_err_out, busy_out
  );

endinterface

// File: rtl/serial_parity_checker_acc.sv
// Bit-serial XOR accumulator: clear beats load, load beats enable.
module parity_acc (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic en,
  input  logic bit_in,
  output logic acc
);

  // Running XOR of the bits fed in since the last load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc <= 1'b0;
    else if (clear) acc <= 1'b0;
    else if (load)  acc <= bit_in;
    else if (en)    acc <= acc ^ bit_in;
  end

endmodule

// File: rtl/serial_parity_checker.sv
// Receives DATA_W data bits LSB first plus one parity bit and checks parity.
module serial_parity_checker #(
  parameter int   DATA_W     = 8,
  parameter logic PARITY_ODD = 1'b0
) (
  input logic                    clk_in,
  input logic                    rst_n_in,
  serial_parity_checker_if.slave bus
);

  import parity_pkg::*;

  localparam int             CW      = $clog2(DATA_W + 1);
  localparam logic [CW-1:0]  LAST    = CW'(DATA_W);
  localparam logic           EXP_PAR = PARITY_ODD ? parity_pkg::PARITY_ODD
                                                  : parity_pkg::PARITY_EVEN;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] shreg;
  logic              acc;
  logic              acc_clear;
  logic              acc_load;
  logic              acc_en;

  // Accumulator control: a start bit always (re)loads, even mid-frame.
  always_comb begin
    acc_load  = bus.bit_valid_in &  bus.frame_start_in;
    acc_en    = bus.bit_valid_in & ~bus.frame_start_in & (state == DATA);
    acc_clear = bus.bit_valid_in & ~bus.frame_start_in & (state == PARITY);
  end

  parity_acc u_acc (
    .clk    (clk_in),
    .rst_n  (rst_n_in),
    .clear  (acc_clear),
    .load   (acc_load),
    .en     (acc_en),
    .bit_in (bus.ser_in),
    .acc    (acc)
  );

  // Frame FSM, bit counter, shift register and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state              <= IDLE;
      cnt                <= '0;
      shreg              <= '0;
      bus.data_out       <= '0;
      bus.data_valid_out <= 1'b0;
      bus.parity_err_out <= 1'b0;
      bus.frame_err_out  <= 1'b0;
      bus.busy_out       <= 1'b0;
    end else begin
      bus.data_valid_out <= 1'b0;
      bus.frame_err_out  <= 1'b0;
      if (bus.bit_valid_in) begin
        if (bus.frame_start_in) begin
          // A start bit mid-frame aborts the partial frame and begins a new one.
          if (state != IDLE) bus.frame_err_out <= 1'b1;
          shreg        <= DATA_W'(bus.ser_in);
          cnt          <= CW'(1);
          state        <= (DATA_W == 1) ? PARITY : DATA;
          bus.busy_out <= 1'b1;
        end else begin
          unique case (state)
            IDLE: ;
            DATA: begin
              shreg <= shreg | (DATA_W'(bus.ser_in) << cnt);
              cnt   <= cnt + CW'(1);
              if (cnt + CW'(1) == LAST) state <= PARITY;
            end
            PARITY: begin
              bus.data_out       <= shreg;
              bus.parity_err_out <= acc ^ bus.ser_in ^ EXP_PAR;
              bus.data_valid_out <= 1'b1;
              bus.busy_out       <= 1'b0;
              cnt                <= '0;
              state              <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: even and odd instances share one stream.
module tb_serial_parity_checker;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_parity_checker_if #(.DATA_W(W)) if_e ();
  serial_parity_checker_if #(.DATA_W(W)) if_o ();

  serial_parity_checker #(.DATA_W(W), .PARITY_ODD(1'b0)) dut_e (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (if_e)
  );

  serial_parity_checker #(.DATA_W(W), .PARITY_ODD(1'b1)) dut_o (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (if_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: frame contents as a queue of bits.
  bit           q[$];
  bit           m_in_frame;
  logic [W-1:0] m_data;
  bit           m_valid, m_ferr, m_perr_e, m_perr_o;
  int           n_valid, n_ferr;

  typedef struct {
    logic [7:0] word;
    logic       par;
    logic       perr_e;
    logic       perr_o;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_in_frame = 1'b0;
    m_data     = '0;
    m_valid    = 1'b0;
    m_ferr     = 1'b0;
    m_perr_e   = 1'b0;
    m_perr_o   = 1'b0;
  endfunction

  function automatic void model_step(input bit v, input bit s, input bit b);
    logic [W-1:0] w;
    int ones;
    m_valid = 1'b0;
    m_ferr  = 1'b0;
    if (!v) return;
    if (s) begin
      if (m_in_frame) m_ferr = 1'b1;
      q.delete();
      q.push_back(b);
      m_in_frame = 1'b1;
    end else if (m_in_frame) begin
      if (q.size() < W) begin
        q.push_back(b);
      end else begin
        w    = '0;
        ones = 0;
        foreach (q[i]) begin
          w[i] = q[i];
          ones += int'(q[i]);
        end
        ones += int'(b);
        m_data     = w;
        m_valid    = 1'b1;
        m_perr_e   = (ones % 2) != 0;
        m_perr_o   = (ones % 2) != 1;
        m_in_frame = 1'b0;
      end
    end
  endfunction

  task automatic check_outputs();
    chk("data_e",  32'(if_e.data_out),       32'(m_data));
    chk("data_o",  32'(if_o.data_out),       32'(m_data));
    chk("valid_e", 32'(if_e.data_valid_out), 32'(m_valid));
    chk("valid_o", 32'(if_o.data_valid_out), 32'(m_valid));
    chk("ferr_e",  32'(if_e.frame_err_out),  32'(m_ferr));
    chk("ferr_o",  32'(if_o.frame_err_out),  32'(m_ferr));
    chk("busy_e",  32'(if_e.busy_out),       32'(m_in_frame));
    chk("busy_o",  32'(if_o.busy_out),       32'(m_in_frame));
    if (m_valid) begin
      chk("perr_e", 32'(if_e.parity_err_out), 32'(m_perr_e));
      chk("perr_o", 32'(if_o.parity_err_out), 32'(m_perr_o));
    end
    n_valid += int'(if_e.data_valid_out);
    n_ferr  += int'(if_e.frame_err_out);
  endtask

  task automatic step(input bit v, input bit s, input bit b);
    if_e.bit_valid_in   = v;
    if_e.frame_start_in = s;
    if_e.ser_in         = b;
    if_o.bit_valid_in   = v;
    if_o.frame_start_in = s;
    if_o.ser_in         = b;
    model_step(v, s, b);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Idle gaps toggle frame_start_in with bit_valid_in low; it must be ignored.
  task automatic send_frame(input logic [W-1:0] word, input bit par, input int gap);
    step(1'b1, 1'b1, word[0]);
    for (int i = 1; i < W; i++) begin
      repeat (gap) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step(1'b1, 1'b0, word[i]);
    end
    repeat (gap) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    step(1'b1, 1'b0, par);
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_data"},  32'(if_e.data_out),       32'd0);
    chk({nm, "_valid"}, 32'(if_e.data_valid_out), 32'd0);
    chk({nm, "_perr"},  32'(if_e.parity_err_out), 32'd0);
    chk({nm, "_ferr"},  32'(if_e.frame_err_out),  32'd0);
    chk({nm, "_busy"},  32'(if_e.busy_out),       32'd0);
    chk({nm, "_busyo"}, 32'(if_o.busy_out),       32'd0);
  endtask

  initial begin
    vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b1};
    vt[1] = '{8'hA5, 1'b1, 1'b1, 1'b0};
    vt[2] = '{8'h01, 1'b0, 1'b1, 1'b0};
    vt[3] = '{8'h01, 1'b1, 1'b0, 1'b1};
    vt[4] = '{8'hFF, 1'b0, 1'b0, 1'b1};
    vt[5] = '{8'h00, 1'b0, 1'b0, 1'b1};
    vt[6] = '{8'h00, 1'b1, 1'b1, 1'b0};

    if_e.bit_valid_in = 1'b0; if_e.frame_start_in = 1'b0; if_e.ser_in = 1'b0;
    if_o.bit_valid_in = 1'b0; if_o.frame_start_in = 1'b0; if_o.ser_in = 1'b0;
    model_reset();
    n_valid = 0;
    n_ferr  = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Table of complete frames, back to back, continuous bit_valid_in.
    foreach (vt[i]) begin
      send_frame(vt[i].word, vt[i].par, 0);
      chk("tbl_data",  32'(if_e.data_out),       32'(vt[i].word));
      chk("tbl_valid", 32'(if_e.data_valid_out), 32'd1);
      chk("tbl_perr_e", 32'(if_e.parity_err_out), 32'(vt[i].perr_e));
      chk("tbl_perr_o", 32'(if_o.parity_err_out), 32'(vt[i].perr_o));
    end
    step(1'b0, 1'b0, 1'b0);
    chk("valid_drops", 32'(if_e.data_valid_out), 32'd0);

    // Gapped frame: busy stays high across gaps, exactly one valid pulse.
    n_valid = 0;
    send_frame(8'h3C, 1'b0, 3);
    chk("gap_data",   32'(if_e.data_out),       32'h3C);
    chk("gap_perr",   32'(if_e.parity_err_out), 32'd0);
    step(1'b0, 1'b0, 1'b0);
    chk("gap_nvalid", 32'(n_valid), 32'd1);

    // Abort at data bit 5 with the start of a full 0x0F frame.
    n_valid = 0;
    n_ferr  = 0;
    step(1'b1, 1'b1, 1'b1);
    for (int i = 1; i < 5; i++) step(1'b1, 1'b0, 1'(i % 2));
    step(1'b1, 1'b1, 1'b1);
    chk("abort_ferr", 32'(if_e.frame_err_out), 32'd1);
    chk("abort_busy", 32'(if_e.busy_out), 32'd1);
    for (int i = 1; i < W; i++) step(1'b1, 1'b0, 1'(i < 4));
    step(1'b1, 1'b0, 1'b0);
    chk("abort_data",   32'(if_e.data_out), 32'h0F);
    chk("abort_perr",   32'(if_e.parity_err_out), 32'd0);
    chk("abort_nvalid", 32'(n_valid), 32'd1);
    chk("abort_nferr",  32'(n_ferr),  32'd1);

    // Reset asserted at data bit 4, then a clean 0xFF frame.
    step(1'b1, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) step(1'b1, 1'b0, 1'b1);
    if_e.bit_valid_in = 1'b0;
    if_o.bit_valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    check_all_zero("midrst_hold");
    rst_n = 1'b1;
    send_frame(8'hFF, 1'b0, 0);
    chk("rst_data", 32'(if_e.data_out),       32'hFF);
    chk("rst_perr", 32'(if_e.parity_err_out), 32'd0);

    // Random stream against the model.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 11) == 0),
           1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
